pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller for the 5-stage RISC-V core. It replaces the purely combinational hazard unit with a sequenced controller. Additions: load-use bubbles of configurable length, register-use qualification (no false hazards on x0 or unused operands), an N-source stall vector, trap/return redirects that are latched while the pipeline is stalled, and saturating performance counters. Sits between the IF/ID/EXE stage control and the pipeline register enables, PC write enable and flush muxes.

## Interface
- NUM_STALL_SRC, 3, number of external stall requesters (bit0 IM, bit1 DM, bit2 CSR; more allowed)
- LOAD_LAT, 1, load-use bubble cycles inserted per hazard, legal 1..4
- REG_AW, 5, register address width
- CNT_W, 16, performance counter width

- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- stall_src  in  NUM_STALL_SRC  per-source stall request (level)
- id_mem_read  in  1  instruction in ID/EXE boundary is a load
- id_rd_addr  in  REG_AW  destination of that load
- rs1_addr, rs2_addr  in  REG_AW each  source registers of the instruction in IF/ID
- rs1_used, rs2_used  in  1 each  operand actually read by that instruction
- br_redirect  in  1  branch/jump taken in EXE (level, stable while stalled)
- trap_req  in  1  single-cycle pulse: CSR trap entry or mret
- pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we  out  1 each  write enables
- if_flush  out  1  zero the IF/ID instruction
- id_flush  out  1  turn the ID/EXE control word into a NOP
- trap_ack  out  1  one-cycle pulse when a trap redirect is applied
- trap_pending  out  1  trap latched, not yet applied
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters
- cnt_clr  in  1  synchronous counter clear

## Operation
- any_stall = OR of stall_src.
- lu_hit = id_mem_read & (id_rd_addr != 0) & ((rs1_used & id_rd_addr==rs1_addr) | (rs2_used & id_rd_addr==rs2_addr)).
- trap_live = trap_req | trap_pending.
- redir = br_redirect | trap_live.
- State machine: RUN, LU_BUBBLE (remaining-bubble counter rem, width 2).
- Priority, highest first: rst > any_stall > redir > load-use > normal.
- any_stall:
  - All five enables are 0; flushes are 0; trap_ack is 0.
  - State and rem are frozen.
  - A trap_req pulse sets trap_pending.
- redir, no stall:
  - if_flush=1, id_flush=1, all enables 1.
  - If trap_live: trap_ack=1 and trap_pending clears next cycle.
  - Any load-use sequence is aborted; state becomes RUN.
- Load-use bubble, no stall and no redir (RUN with lu_hit, or state LU_BUBBLE):
  - id_flush=1, pc_we=0, if_id_we=0; the other enables are 1.
  - RUN with lu_hit and LOAD_LAT>1: go to LU_BUBBLE with rem=LOAD_LAT-1.
  - LU_BUBBLE: rem decrements; leave to RUN after the bubble cycle where rem==1.
  - lu_hit is not evaluated while in LU_BUBBLE.
- Normal: all enables 1, flushes 0.
- Counters (saturate at all-ones; cnt_clr zeroes them and beats an increment in the same cycle):
  - stall_cnt +1 per any_stall cycle.
  - bubble_cnt +1 per load-use bubble cycle.
  - flush_cnt +1 per if_flush cycle.

## Timing
- Enables, flushes and trap_ack are combinational from current inputs and registered state; they take effect on the same edge.
- Registered state (state, rem, trap_pending, counters) updates on the rising clk edge.
- Load-use hazard costs exactly LOAD_LAT non-stalled cycles of held PC and IF/ID. Stall cycles inside the sequence do not consume bubbles.
- trap_req in a non-stalled cycle: applied the same cycle, trap_pending never sets.
- trap_req during a stall: applied in the first non-stalled cycle.
- A second trap_req while trap_pending=1 merges; exactly one trap_ack results.
- rst high:
  - All enables 0, flushes 0, trap_ack 0.
  - Next cycle: state=RUN, rem=0, trap_pending=0, counters 0.
  - rst mid-sequence discards pending trap and remaining bubbles.

## Test plan
- LOAD_LAT=2, lw x5 then add x6,x5,x1 -> 2 cycles of pc_we=0/if_id_we=0/id_flush=1, then normal; bubble_cnt=2.
- id_rd_addr=0 with rs1_addr=0, or rs2 match with rs2_used=0 -> no bubble, all enables 1.
- LOAD_LAT=3, stall_src[1] high for 4 cycles after the first bubble -> enables 0 for 4 cycles, then 2 more bubbles; stall_cnt=4, bubble_cnt=3.
- trap_req pulse with stall_src[0] high for 3 cycles -> trap_pending=1 for 3 cycles, then one cycle of if_flush=id_flush=trap_ack=1; flush_cnt=1.
- br_redirect together with lu_hit -> flushes=1, pc_we=1, state stays RUN, bubble_cnt unchanged.
- CNT_W=4, 20 stall cycles -> stall_cnt holds 15; cnt_clr -> 0 next cycle; rst during LU_BUBBLE -> RUN, outputs quiet while rst high.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Sequences load-use bubbles, external stalls and branch/trap redirects,
// holds trap requests that arrive while the pipeline is stalled, and
// keeps saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int NUM_STALL_SRC = 3,
  parameter int LOAD_LAT      = 1,
  parameter int REG_AW        = 5,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_STALL_SRC-1:0] stall_src,
  input  logic                     id_mem_read,
  input  logic [REG_AW-1:0]        id_rd_addr,
  input  logic [REG_AW-1:0]        rs1_addr,
  input  logic [REG_AW-1:0]        rs2_addr,
  input  logic                     rs1_used,
  input  logic                     rs2_used,
  input  logic                     br_redirect,
  input  logic                     trap_req,
  input  logic                     cnt_clr,
  output logic                     pc_we,
  output logic                     if_id_we,
  output logic                     id_exe_we,
  output logic                     exe_mem_we,
  output logic                     mem_wb_we,
  output logic                     if_flush,
  output logic                     id_flush,
  output logic                     trap_ack,
  output logic                     trap_pending,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  typedef enum logic {RUN, LU_BUBBLE} state_t;

  // Bubbles still owed after the first one; LOAD_LAT is at most 4.
  localparam logic [1:0] REM_INIT = 2'(LOAD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       trap_pend_d;
  logic       any_stall, lu_hit, trap_live, redir, bubble;

  assign any_stall = |stall_src;
  assign lu_hit    = id_mem_read && (id_rd_addr != '0) &&
                     ((rs1_used && (id_rd_addr == rs1_addr)) ||
                      (rs2_used && (id_rd_addr == rs2_addr)));
  assign trap_live = trap_req | trap_pending;
  assign redir     = br_redirect | trap_live;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != '1)) ? CNT_W'(v + 1'b1) : v;
  endfunction

  // Priority decode of enables/flushes plus next-state for the bubble FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned; a missed branch would otherwise infer a latch.
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_exe_we   = 1'b0;
    exe_mem_we  = 1'b0;
    mem_wb_we   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    trap_ack    = 1'b0;
    bubble      = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;
    trap_pend_d = trap_pending;

    if (rst) begin
      // Everything held quiet; the register block clears the state.
    end else if (any_stall) begin
      // Freeze the sequence, but remember a trap that shows up meanwhile.
      trap_pend_d = trap_pending | trap_req;
    end else if (redir) begin
      {pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we} = '1;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      trap_ack    = trap_live;
      trap_pend_d = 1'b0;
      state_d     = RUN;
      rem_d       = '0;
    end else if ((state_q == LU_BUBBLE) || lu_hit) begin
      bubble     = 1'b1;
      id_exe_we  = 1'b1;
      exe_mem_we = 1'b1;
      mem_wb_we  = 1'b1;
      id_flush   = 1'b1;
      if (state_q == LU_BUBBLE) begin
        if (rem_q <= 2'd1) begin
          state_d = RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end else if (LOAD_LAT > 1) begin
        state_d = LU_BUBBLE;
        rem_d   = REM_INIT;
      end
    end else begin
      {pc_we, if_id_we, id_exe_we, exe_mem_we, mem_wb_we} = '1;
    end
  end

  // State, pending trap and performance counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= RUN;
      rem_q        <= '0;
      trap_pending <= 1'b0;
      stall_cnt    <= '0;
      bubble_cnt   <= '0;
      flush_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      trap_pending <= trap_pend_d;
      if (cnt_clr) begin
        stall_cnt  <= '0;
        bubble_cnt <= '0;
        flush_cnt  <= '0;
      end else begin
        stall_cnt  <= sat_inc(stall_cnt, any_stall);
        bubble_cnt <= sat_inc(bubble_cnt, bubble);
        flush_cnt  <= sat_inc(flush_cnt, if_flush);
      end
    end
  end

endmodule
